// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides.
// Flags come only from the registered occupancy count, so no input reaches an output combinationally.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_val,
  output logic             data_in_rdy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_val,
  input  logic             data_out_rdy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] buffer [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic w_push;
  logic w_pop;

  // DEPTH need not be a power of two, so wrap explicitly rather than by overflow
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign data_in_rdy  = (count != CW'(DEPTH));
  assign data_out_val = (count != '0);
  assign data_out     = buffer[rd_ptr];

  assign w_push = data_in_val & data_in_rdy;
  assign w_pop  = data_out_val & data_out_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (w_push) wr_ptr <= ptr_inc(wr_ptr);
      if (w_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({w_push, w_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; stale words sit behind data_out_val=0.
  always_ff @(posedge clk) begin
    if (w_push) buffer[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a queue model predicts flags, occupancy and popped data.
module tb_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             data_in_val;
  logic             data_in_rdy;
  logic [WIDTH-1:0] data_out;
  logic             data_out_val;
  logic             data_out_rdy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] q[$];

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_val  (data_in_val),
    .data_in_rdy  (data_in_rdy),
    .data_out     (data_out),
    .data_out_val (data_out_val),
    .data_out_rdy (data_out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: predict handshake from the model, verify head data, advance, re-check state.
  task automatic tick();
    bit push, pop;
    logic [WIDTH-1:0] din;
    push = data_in_val && (q.size() < DEPTH);
    pop  = data_out_rdy && (q.size() != 0);
    din  = data_in;
    if (pop) check("pop_data", 32'(data_out), 32'(q[0]));
    @(posedge clk);
    #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(din);
    check("count", 32'(dut.count), 32'(q.size()));
    check("in_rdy", 32'(data_in_rdy), 32'(q.size() != DEPTH));
    check("out_val", 32'(data_out_val), 32'(q.size() != 0));
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    data_in = d; data_in_val = 1'b1; data_out_rdy = 1'b0;
    tick();
    data_in_val = 1'b0;
  endtask

  task automatic drain();
    data_in_val = 1'b0; data_out_rdy = 1'b1;
    for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) tick();
    data_out_rdy = 1'b0;
    check("drained", 32'(data_out_val), 32'(0));
  endtask

  initial begin
    reset = 1'b0; data_in = '0; data_in_val = 1'b0; data_out_rdy = 1'b0;
    #12;
    check("rst_in_rdy", 32'(data_in_rdy), 32'(1));
    check("rst_out_val", 32'(data_out_val), 32'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Fill 0x01..0x0A, then an 11th offer must be refused
    for (int i = 1; i <= DEPTH; i++) push_word(WIDTH'(i));
    check("full_in_rdy", 32'(data_in_rdy), 32'(0));
    push_word(8'hFF);
    check("full_count", 32'(dut.count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) check("buf_fill", 32'(dut.buffer[i]), 32'(i + 1));

    // Drain in order, then a push must land at wrapped slot 0
    drain();
    push_word(8'h11);
    check("wrap_buf0", 32'(dut.buffer[0]), 32'h11);
    check("wrap_out", 32'(data_out), 32'h11);
    drain();

    // Asynchronous reset with 5 words queued
    for (int i = 0; i < 5; i++) push_word(8'h50 + WIDTH'(i));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_val", 32'(data_out_val), 32'(0));
    check("mid_rst_in_rdy", 32'(data_in_rdy), 32'(1));
    q.delete();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    push_word(8'h3C);
    check("post_rst_val", 32'(data_out_val), 32'(1));
    check("post_rst_data", 32'(data_out), 32'h3C);
    drain();

    // Steady-state simultaneous push/pop at occupancy 4
    for (int i = 0; i < 4; i++) push_word(8'h80 + WIDTH'(i));
    data_in_val = 1'b1; data_out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'h84 + WIDTH'(i);
      tick();
      check("pp_count4", 32'(dut.count), 32'(4));
    end
    drain();

    // Full boundary: push+pop while full pops only; push is taken next cycle
    for (int i = 0; i < DEPTH; i++) push_word(8'hA0 + WIDTH'(i));
    data_in = 8'hAA; data_in_val = 1'b1; data_out_rdy = 1'b1;
    tick();
    check("bnd_count9", 32'(dut.count), 32'(9));
    data_out_rdy = 1'b0;
    tick();
    check("bnd_count10", 32'(dut.count), 32'(10));
    drain();

    // Random traffic against the scoreboard queue
    for (int i = 0; i < 100; i++) begin
      data_in      = WIDTH'($urandom_range(0, 255));
      data_in_val  = 1'($urandom_range(0, 1));
      data_out_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
